// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, register constants and grant encoding for the writeback arbiter.
package regfile_wb_arbiter_pkg;
    localparam int WORD_W = 64;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 16;
    localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_MEM  = 2'd2
    } grant_e;

    function automatic logic is_zero_reg(input logic [REG_W-1:0] r);
        return r == ZERO_REG;
    endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester handshakes, regfile write port, bypass lookup and conflict counter.
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic              alu_valid;
    logic              alu_ready;
    logic [REG_W-1:0]  alu_reg;
    logic [WORD_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [REG_W-1:0]  mem_reg;
    logic [WORD_W-1:0] mem_data;
    logic              regWrite;
    logic [REG_W-1:0]  write_reg;
    logic [WORD_W-1:0] write_data;
    logic [REG_W-1:0]  query_reg;
    logic              query_hit;
    logic [WORD_W-1:0] query_data;
    logic [CNT_W-1:0]  conflict_cnt;

    modport slave (
        input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, query_reg,
        output alu_ready, mem_ready, regWrite, write_reg, write_data,
               query_hit, query_data, conflict_cnt
    );

    modport master (
        output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, query_reg,
        input  alu_ready, mem_ready, regWrite, write_reg, write_data,
               query_hit, query_data, conflict_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter_wb_hold_slot.sv
// One-entry writeback holding slot; a load on the same edge as a clear keeps the slot full.
module wb_hold_slot
    import regfile_wb_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [REG_W-1:0]  i_reg,
    input  logic [WORD_W-1:0] i_data,
    output logic              o_valid,
    output logic [REG_W-1:0]  o_reg,
    output logic [WORD_W-1:0] o_data
);
    logic              r_valid;
    logic [REG_W-1:0]  r_reg;
    logic [WORD_W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_reg  <= i_reg;
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_reg   = r_reg;
    assign o_data  = r_data;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between ALU and load writeback slots,
// with a registered write stage, a same-cycle bypass lookup and a conflict counter.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input logic                 clk,
    input logic                 reset,
    regfile_wb_arbiter_if.slave bus
);
    logic              w_alu_v, w_mem_v;
    logic [REG_W-1:0]  w_alu_reg, w_mem_reg;
    logic [WORD_W-1:0] w_alu_data, w_mem_data;
    logic              w_alu_load, w_mem_load;
    logic              w_alu_hit, w_mem_hit, w_out_hit;
    grant_e            w_grant;

    logic              r_regwrite;
    logic [REG_W-1:0]  r_write_reg;
    logic [WORD_W-1:0] r_write_data;
    logic              r_last_alu;
    logic              r_alu_younger;
    logic [CNT_W-1:0]  r_conflict;

    // Ready depends only on slot state and grant, never on the incoming valid.
    assign bus.alu_ready = !w_alu_v || (w_grant == GNT_ALU);
    assign bus.mem_ready = !w_mem_v || (w_grant == GNT_MEM);
    assign w_alu_load    = bus.alu_valid && bus.alu_ready && !is_zero_reg(bus.alu_reg);
    assign w_mem_load    = bus.mem_valid && bus.mem_ready && !is_zero_reg(bus.mem_reg);

    wb_hold_slot u_alu_slot (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_alu_load),
        .i_clear (w_grant == GNT_ALU),
        .i_reg   (bus.alu_reg),
        .i_data  (bus.alu_data),
        .o_valid (w_alu_v),
        .o_reg   (w_alu_reg),
        .o_data  (w_alu_data)
    );

    wb_hold_slot u_mem_slot (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_mem_load),
        .i_clear (w_grant == GNT_MEM),
        .i_reg   (bus.mem_reg),
        .i_data  (bus.mem_data),
        .o_valid (w_mem_v),
        .o_reg   (w_mem_reg),
        .o_data  (w_mem_data)
    );

    // Same destination: older slot first to keep WAW order; otherwise round-robin.
    always_comb begin
        w_grant = GNT_NONE;
        if (w_alu_v && w_mem_v) begin
            if (w_alu_reg == w_mem_reg) begin
                w_grant = r_alu_younger ? GNT_MEM : GNT_ALU;
            end else begin
                w_grant = r_last_alu ? GNT_MEM : GNT_ALU;
            end
        end else if (w_alu_v) begin
            w_grant = GNT_ALU;
        end else if (w_mem_v) begin
            w_grant = GNT_MEM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_regwrite    <= 1'b0;
            r_write_reg   <= '0;
            r_write_data  <= '0;
            r_last_alu    <= 1'b1;
            r_alu_younger <= 1'b0;
            r_conflict    <= '0;
        end else begin
            r_regwrite <= (w_grant != GNT_NONE);
            if (w_grant == GNT_ALU) begin
                r_write_reg  <= w_alu_reg;
                r_write_data <= w_alu_data;
                r_last_alu   <= 1'b1;
            end else if (w_grant == GNT_MEM) begin
                r_write_reg  <= w_mem_reg;
                r_write_data <= w_mem_data;
                r_last_alu   <= 1'b0;
            end
            // The most recent load is the younger one; a joint load makes ALU younger.
            if (w_alu_load) begin
                r_alu_younger <= 1'b1;
            end else if (w_mem_load) begin
                r_alu_younger <= 1'b0;
            end
            if (w_alu_v && w_mem_v && (r_conflict != {CNT_W{1'b1}})) begin
                r_conflict <= r_conflict + 1'b1;
            end
        end
    end

    assign w_alu_hit = w_alu_v && (w_alu_reg == bus.query_reg);
    assign w_mem_hit = w_mem_v && (w_mem_reg == bus.query_reg);
    assign w_out_hit = r_regwrite && (r_write_reg == bus.query_reg);

    always_comb begin
        bus.query_hit  = !is_zero_reg(bus.query_reg) && (w_alu_hit || w_mem_hit || w_out_hit);
        bus.query_data = '0;
        if (w_alu_hit && (r_alu_younger || !w_mem_hit)) begin
            bus.query_data = w_alu_data;
        end else if (w_mem_hit) begin
            bus.query_data = w_mem_data;
        end else if (w_out_hit) begin
            bus.query_data = r_write_data;
        end
    end

    assign bus.regWrite     = r_regwrite;
    assign bus.write_reg    = r_write_reg;
    assign bus.write_data   = r_write_data;
    assign bus.conflict_cnt = r_conflict;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single source, round-robin, WAW, XZR, saturation.
module tb_regfile_wb_arbiter;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
        bus.alu_reg   = '0;
        bus.mem_reg   = '0;
        bus.alu_data  = '0;
        bus.mem_data  = '0;
        bus.query_reg = 5'd31;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int   viol;
        logic [4:0]  exp_reg;
        logic [63:0] exp_data;
        n_checks = 0;
        n_fail   = 0;
        idle();

        // Reset held two cycles with a live ALU request
        reset = 1'b1;
        bus.alu_valid = 1'b1;
        bus.alu_reg   = 5'd7;
        bus.alu_data  = 64'd55;
        bus.query_reg = 5'd7;
        tick();
        tick();
        chk("rst_regwrite", bus.regWrite, 1'b0);
        chk("rst_alu_ready", bus.alu_ready, 1'b1);
        chk("rst_mem_ready", bus.mem_ready, 1'b1);
        chk("rst_conflict", bus.conflict_cnt, 16'd0);
        chk("rst_query_hit", bus.query_hit, 1'b0);
        reset = 1'b0;
        bus.alu_valid = 1'b0;
        tick();
        chk("post_rst_wr0", bus.regWrite, 1'b0);
        tick();
        chk("post_rst_wr1", bus.regWrite, 1'b0);

        // ALU only
        bus.alu_valid = 1'b1;
        bus.alu_reg   = 5'd9;
        bus.alu_data  = 64'd256;
        tick();
        bus.alu_valid = 1'b0;
        bus.query_reg = 5'd9;
        #1;
        chk("alu_pend_wr", bus.regWrite, 1'b0);
        chk("alu_pend_hit", bus.query_hit, 1'b1);
        chk("alu_pend_data", bus.query_data, 64'd256);
        tick();
        chk("alu_wr", bus.regWrite, 1'b1);
        chk("alu_wreg", bus.write_reg, 5'd9);
        chk("alu_wdata", bus.write_data, 64'd256);
        tick();
        chk("alu_wr_done", bus.regWrite, 1'b0);

        // Same-edge requests to different registers: mem first after reset
        do_reset();
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd3; bus.alu_data = 64'hA;
        bus.mem_valid = 1'b1; bus.mem_reg = 5'd4; bus.mem_data = 64'hB;
        tick();
        idle();
        #1;
        chk("rr_alu_ready", bus.alu_ready, 1'b0);
        chk("rr_mem_ready", bus.mem_ready, 1'b1);
        tick();
        chk("rr_first_wr", bus.regWrite, 1'b1);
        chk("rr_first_reg", bus.write_reg, 5'd4);
        chk("rr_first_data", bus.write_data, 64'hB);
        tick();
        chk("rr_second_wr", bus.regWrite, 1'b1);
        chk("rr_second_reg", bus.write_reg, 5'd3);
        chk("rr_second_data", bus.write_data, 64'hA);
        chk("rr_conflict", bus.conflict_cnt, 16'd1);

        // WAW on register 5: older mem value first, bypass returns the ALU value
        do_reset();
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd5; bus.alu_data = 64'd1;
        bus.mem_valid = 1'b1; bus.mem_reg = 5'd5; bus.mem_data = 64'd2;
        tick();
        idle();
        bus.query_reg = 5'd5;
        #1;
        chk("waw_q_hit0", bus.query_hit, 1'b1);
        chk("waw_q_data0", bus.query_data, 64'd1);
        tick();
        chk("waw_first_reg", bus.write_reg, 5'd5);
        chk("waw_first_data", bus.write_data, 64'd2);
        chk("waw_q_data1", bus.query_data, 64'd1);
        tick();
        chk("waw_second_data", bus.write_data, 64'd1);
        chk("waw_q_hit2", bus.query_hit, 1'b1);
        chk("waw_q_data2", bus.query_data, 64'd1);
        tick();
        chk("waw_idle_wr", bus.regWrite, 1'b0);
        chk("waw_q_hit3", bus.query_hit, 1'b0);

        // Write to the zero register is dropped
        do_reset();
        bus.mem_valid = 1'b1; bus.mem_reg = 5'd31; bus.mem_data = 64'd77;
        #1;
        chk("xzr_ready", bus.mem_ready, 1'b1);
        tick();
        idle();
        bus.query_reg = 5'd31;
        #1;
        chk("xzr_q_hit", bus.query_hit, 1'b0);
        chk("xzr_ready_after", bus.mem_ready, 1'b1);
        tick();
        chk("xzr_wr0", bus.regWrite, 1'b0);
        tick();
        chk("xzr_wr1", bus.regWrite, 1'b0);

        // Sustained contention: strict alternation and counter saturation
        do_reset();
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd1; bus.alu_data = 64'h111;
        bus.mem_valid = 1'b1; bus.mem_reg = 5'd2; bus.mem_data = 64'h222;
        viol = 0;
        for (int i = 0; i < 70000; i++) begin
            tick();
            if (i == 0) begin
                chk("stream_first_idle", bus.regWrite, 1'b0);
            end else begin
                exp_reg  = (i % 2 == 1) ? 5'd2 : 5'd1;
                exp_data = (i % 2 == 1) ? 64'h222 : 64'h111;
                if (bus.regWrite !== 1'b1 || bus.write_reg !== exp_reg ||
                    bus.write_data !== exp_data) begin
                    viol++;
                end
            end
            if (i == 99) begin
                chk("stream_cnt_99", bus.conflict_cnt, 16'd99);
            end
        end
        chk("stream_alt_violations", viol, 0);
        chk("stream_cnt_sat", bus.conflict_cnt, 16'hFFFF);

        // Reset mid-stream with requests still asserted
        reset = 1'b1;
        tick();
        chk("mid_rst_wr", bus.regWrite, 1'b0);
        chk("mid_rst_reg", bus.write_reg, 5'd0);
        chk("mid_rst_data", bus.write_data, 64'd0);
        chk("mid_rst_cnt", bus.conflict_cnt, 16'd0);
        reset = 1'b0;
        idle();
        tick();
        chk("mid_rst_wr_a", bus.regWrite, 1'b0);
        chk("mid_rst_alu_ready", bus.alu_ready, 1'b1);
        chk("mid_rst_mem_ready", bus.mem_ready, 1'b1);
        tick();
        chk("mid_rst_wr_b", bus.regWrite, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
